// File: rtl/fifo_reader_m.sv
// fifo_reader_m: drains an N x N matrix from a FIFO one element at a time, tagging each with row/col (FIFO_READER_DIM_CHK_EN adds err + dimension check).
// Latency: element presented 3 cycles after start or after the previous accept; pop is combinational in FETCH.
// Backpressure: presented element held until out_ready; an empty FIFO parks the reader in FETCH.
module fifo_reader_m #(
   parameter int DW   = 8,
   parameter int NMAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [3:0]               N,
   input  logic                     fifo_empty,
   input  logic [DW-1:0]            fifo_data,
   input  logic                     out_ready,
   output logic                     pop,
   output logic [DW-1:0]            data_out,
   output logic                     data_valid,
   output logic [$clog2(NMAX)-1:0]  row,
   output logic [$clog2(NMAX)-1:0]  col,
   output logic                     row_last,
   output logic                     mat_last,
   output logic                     busy,
   output logic                     done
`ifdef FIFO_READER_DIM_CHK_EN
   ,
   output logic                     err
`endif
);

   localparam int IW = $clog2(NMAX);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] n_q;
   logic       start_ok;
   logic       col_end;
   logic       row_end;

`ifdef FIFO_READER_DIM_CHK_EN
   assign start_ok = start && (N != 4'd0) && ({28'd0, N} <= 32'(NMAX));
`else
   assign start_ok = start;
`endif

   assign col_end = (32'(col) + 32'd1 >= 32'(n_q));
   assign row_end = (32'(row) + 32'd1 >= 32'(n_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start_ok) state_nxt = S_FETCH;
         S_FETCH:   if (!fifo_empty) state_nxt = S_WAIT;
         S_WAIT:    state_nxt = S_PRESENT;
         S_PRESENT: if (out_ready) state_nxt = mat_last ? S_DONE : S_FETCH;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      data_valid = 1'b0;
      done       = 1'b0;
      case (state)
         S_FETCH:   pop = !fifo_empty;
         S_PRESENT: data_valid = 1'b1;
         S_DONE:    done = 1'b1;
         default:   ;
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign row_last = data_valid && col_end;
   assign mat_last = row_last && row_end;

   // Datapath: dimension latch, element capture and row/col walk.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q      <= 4'd0;
         row      <= '0;
         col      <= '0;
         data_out <= '0;
      end else begin
         if (state == S_IDLE && start_ok) begin
            n_q <= N;
            row <= '0;
            col <= '0;
         end
         if (state == S_WAIT) begin
            data_out <= fifo_data;
         end
         if (state == S_PRESENT && out_ready) begin
            if (col_end) begin
               col <= '0;
               row <= row + IW'(1);
            end else begin
               col <= col + IW'(1);
            end
         end
      end
   end

`ifdef FIFO_READER_DIM_CHK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else begin
         err <= (state == S_IDLE) && start && !start_ok;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_reader_m.sv
// Bench for fifo_reader_m: array-backed FIFO model, expected stream derived from element index (row = k/N, col = k%N).
module tb_fifo_reader_m;
   localparam int DW   = 8;
   localparam int NMAX = 8;
   localparam int IW   = $clog2(NMAX);

   logic          clk = 1'b0;
   logic          rst, start, fifo_empty, out_ready;
   logic          pop, data_valid, row_last, mat_last, busy, done;
   logic [3:0]    N;
   logic [DW-1:0] fifo_data, data_out;
   logic [IW-1:0] row, col;
`ifdef FIFO_READER_DIM_CHK_EN
   logic          err;
`endif

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] mem [0:4095];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            pop_total = 0;
   logic          force_empty = 1'b0;
   logic [DW-1:0] exp_dat [0:63];

   fifo_reader_m #(.DW(DW), .NMAX(NMAX)) dut (
      .clk(clk), .rst(rst), .start(start), .N(N), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .out_ready(out_ready), .pop(pop), .data_out(data_out),
      .data_valid(data_valid), .row(row), .col(col), .row_last(row_last),
      .mat_last(mat_last), .busy(busy), .done(done)
`ifdef FIFO_READER_DIM_CHK_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (pop === 1'b1) begin
         fifo_data <= mem[rd_ptr[11:0]];
         rd_ptr    <= rd_ptr + 1;
         pop_total <= pop_total + 1;
      end
   end

   task automatic load(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         mem[wr_ptr[11:0]] = exp_dat[i];
         wr_ptr++;
      end
   endtask

   task automatic fill_random(input int cnt);
      for (int i = 0; i < cnt; i++) exp_dat[i] = DW'($urandom);
   endtask

   // Streams one matrix; stall_k/empty_k < 0 disable the stall / FIFO-empty window.
   task automatic run_matrix(input int n, input bit rand_rdy, input int stall_k, input int stall_len,
                             input int empty_k, input int empty_len, input bit chg_n);
      int k, cyc, base, stall_cnt, empty_cnt, tot;
      tot = n * n; k = 0; cyc = 0; stall_cnt = 0; empty_cnt = 0;
      base = pop_total;
      load(tot);
      force_empty = (empty_k == 0);
      N = 4'(n); start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start n=%0d got %b exp 1", n, busy); end
      while (k < tot && cyc < 4000) begin
         N     = (chg_n && k >= 3) ? 4'd2 : 4'(n);
         start = chg_n && (k == 4);
         if (data_valid === 1'b1) begin
            tests++;
            if (data_out !== exp_dat[k]) begin
               fails++; $display("FAIL data n=%0d k=%0d got %h exp %h", n, k, data_out, exp_dat[k]);
            end
            tests++;
            if (row !== IW'(k / n) || col !== IW'(k % n)) begin
               fails++; $display("FAIL rowcol n=%0d k=%0d got (%0d,%0d) exp (%0d,%0d)", n, k, row, col, k / n, k % n);
            end
            tests++;
            if (row_last !== (k % n == n - 1) || mat_last !== (k == tot - 1)) begin
               fails++; $display("FAIL last_flags n=%0d k=%0d got rl=%b ml=%b", n, k, row_last, mat_last);
            end
            if (k == stall_k && stall_cnt < stall_len) begin
               out_ready = 1'b0;
               stall_cnt++;
               tests++;
               if (pop !== 1'b0) begin fails++; $display("FAIL pop_in_stall k=%0d got %b exp 0", k, pop); end
            end else begin
               out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
               if (out_ready) begin
                  k++;
                  if (k == empty_k) begin force_empty = 1'b1; empty_cnt = 0; end
               end
            end
         end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (force_empty) begin
               tests++;
               if (pop !== 1'b0) begin fails++; $display("FAIL pop_when_empty k=%0d got %b exp 0", k, pop); end
               empty_cnt++;
               if (empty_cnt >= empty_len) force_empty = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      N = 4'(n);
      tests++;
      if (k != tot) begin fails++; $display("FAIL timeout n=%0d got %0d elements exp %0d", n, k, tot); end
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL done_pulse n=%0d got %b exp 1", n, done); end
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL after_done n=%0d got done=%b busy=%b exp 0 0", n, done, busy);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL start_in_done_taken n=%0d got busy=%b exp 0", n, busy); end
      tests++;
      if (pop_total - base != tot) begin
         fails++; $display("FAIL pop_count n=%0d got %0d exp %0d", n, pop_total - base, tot);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; N = 4'd0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (pop !== 1'b0 || data_valid !== 1'b0 || row_last !== 1'b0 || mat_last !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL reset_ctrl got pop=%b dv=%b rl=%b ml=%b busy=%b done=%b exp 0",
                           pop, data_valid, row_last, mat_last, busy, done);
      end
      tests++;
      if (data_out !== '0 || row !== '0 || col !== '0) begin
         fails++; $display("FAIL reset_data got d=%h r=%0d c=%0d exp 0", data_out, row, col);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || pop !== 1'b0) begin fails++; $display("FAIL idle_after_reset got busy=%b pop=%b", busy, pop); end
   endtask

   task automatic test_basic_n2;
      for (int i = 0; i < 4; i++) exp_dat[i] = DW'(8'h0A + i);
      run_matrix(2, 1'b0, -1, 0, -1, 0, 1'b0);
   endtask

   task automatic test_stall;
      fill_random(9);
      run_matrix(3, 1'b0, 4, 5, -1, 0, 1'b0);
   endtask

   task automatic test_empty;
      fill_random(4);
      run_matrix(2, 1'b0, -1, 0, 2, 4, 1'b0);
   endtask

   task automatic test_midreset;
      int base, cyc;
      fill_random(9);
      base = pop_total;
      load(9);
      N = 4'd3; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (pop_total - base < 2 && cyc < 100) begin @(negedge clk); cyc++; end
      tests++;
      if (pop_total - base != 2) begin fails++; $display("FAIL midreset_pops got %0d exp 2", pop_total - base); end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || pop !== 1'b0 || data_valid !== 1'b0 || row_last !== 1'b0 ||
          mat_last !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL midreset_ctrl got busy=%b pop=%b dv=%b done=%b exp 0", busy, pop, data_valid, done);
      end
      tests++;
      if (data_out !== '0 || row !== '0 || col !== '0) begin
         fails++; $display("FAIL midreset_data got d=%h r=%0d c=%0d exp 0", data_out, row, col);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (pop_total - base != 2 || busy !== 1'b0) begin
         fails++; $display("FAIL midreset_quiet got pops=%0d busy=%b exp 2 0", pop_total - base, busy);
      end
      wr_ptr = rd_ptr;
      fill_random(9);
      run_matrix(3, 1'b1, -1, 0, -1, 0, 1'b0);
   endtask

   task automatic test_start_busy;
      fill_random(9);
      run_matrix(3, 1'b1, -1, 0, -1, 0, 1'b1);
   endtask

   task automatic test_n1;
      fill_random(1);
      run_matrix(1, 1'b0, -1, 0, -1, 0, 1'b0);
   endtask

   task automatic test_random;
      int n;
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, NMAX);
         fill_random(n * n);
         run_matrix(n, 1'b1, $urandom_range(0, n * n - 1), $urandom_range(0, 4),
                    $urandom_range(0, n * n - 1), $urandom_range(1, 3), 1'b0);
      end
   endtask

`ifdef FIFO_READER_DIM_CHK_EN
   task automatic test_dim_chk;
      int base, errs;
      for (int t = 0; t < 2; t++) begin
         exp_dat[0] = DW'($urandom);
         base = pop_total;
         load(1);
         N = (t == 0) ? 4'd0 : 4'd9; start = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
         errs = 0;
         for (int c = 0; c < 4; c++) begin
            if (err === 1'b1) errs++;
            tests++;
            if (busy !== 1'b0 || pop !== 1'b0) begin
               fails++; $display("FAIL dim_busy N=%0d got busy=%b pop=%b exp 0 0", N, busy, pop);
            end
            @(negedge clk);
         end
         tests++;
         if (errs != 1) begin fails++; $display("FAIL dim_err N=%0d got %0d err cycles exp 1", N, errs); end
         tests++;
         if (pop_total != base) begin fails++; $display("FAIL dim_pop N=%0d got %0d pops exp 0", N, pop_total - base); end
         wr_ptr = rd_ptr;
      end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; N = 4'd0; out_ready = 1'b0;
      test_reset();
      test_basic_n2();
      test_stall();
      test_empty();
      test_midreset();
      test_start_busy();
      test_n1();
      test_random();
`ifdef FIFO_READER_DIM_CHK_EN
      test_dim_chk();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_reader_m.md
FIFO_READER_M -- requirements
Module: fifo_reader_m

Interface
REQ-001 The block SHALL have parameter DW, default 8, matrix element data width in bits.
REQ-002 The block SHALL have parameter NMAX, default 8, largest supported matrix dimension.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-high; ports SHALL be as listed in REQ-004 to REQ-018.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  write side reports N*N elements loaded; sampled in IDLE only.
REQ-007 Port N  input  4  matrix dimension; sampled with start.
REQ-008 Port fifo_empty  input  1  FIFO empty flag.
REQ-009 Port fifo_data  input  DW  FIFO read data, valid one cycle after pop.
REQ-010 Port out_ready  input  1  downstream accepts the current element.
REQ-011 Port pop  output  1  one-cycle FIFO read strobe.
REQ-012 Port data_out  output  DW  current element.
REQ-013 Port data_valid  output  1  data_out is valid.
REQ-014 Port row  output  $clog2(NMAX)  row index of data_out.
REQ-015 Port col  output  $clog2(NMAX)  column index of data_out.
REQ-016 Port row_last  output  1  data_valid and col == N-1.
REQ-017 Port mat_last  output  1  row_last and row == N-1.
REQ-018 Ports busy and done  output  1 each  busy: state not IDLE; done: one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, WAIT, PRESENT and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch N into n_q, clear row and col, and enter FETCH next cycle.
REQ-021 In FETCH, pop SHALL be 1 exactly when fifo_empty=0 (combinational), and the FSM SHALL enter WAIT on that cycle; with fifo_empty=1 it SHALL stay in FETCH with pop=0.
REQ-022 In WAIT, the block SHALL register fifo_data into data_out and enter PRESENT.
REQ-023 In PRESENT, data_valid SHALL be 1, and data_out, row and col SHALL hold stable until out_ready=1.
REQ-024 On PRESENT with out_ready=1: if col < n_q-1 then col++; else col=0 and row++.
REQ-025 On PRESENT with out_ready=1 and mat_last=1, the FSM SHALL enter DONE; otherwise it SHALL enter FETCH.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 Exactly n_q*n_q pops SHALL occur per matrix, and no pop SHALL occur outside FETCH.
REQ-028 start SHALL be ignored in all states other than IDLE, and N changes after latching SHALL have no effect.
REQ-029 N=1 SHALL produce a single element with row_last=mat_last=1.
REQ-030 start and done in the same cycle (DONE state) SHALL be ignored; start is acted on only once back in IDLE.

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL go to IDLE and n_q, row, col and data_out SHALL be cleared to 0.
REQ-032 During and after reset, pop, data_valid, row_last, mat_last, busy and done SHALL be 0.
REQ-033 A reset mid-matrix SHALL abandon the transfer with no further pop, and FIFO contents are not restored.

Configuration
REQ-034 With macro FIFO_READER_DIM_CHK_EN defined, the block SHALL have an extra output err (1 bit).
REQ-035 With FIFO_READER_DIM_CHK_EN defined, start with N==0 or N>NMAX SHALL be rejected: stay in IDLE, err=1 for one cycle, no pop.
REQ-036 Without FIFO_READER_DIM_CHK_EN, the err port SHALL be absent and N is not checked; N==0 or N>NMAX gives undefined results.

Verification
REQ-037 Bench SHALL cover: N=2, FIFO preloaded A,B,C,D, out_ready=1 -> 4 pops; outputs (0,0)A (0,1)B (1,0)C (1,1)D; row_last on B and D; mat_last on D; done one cycle later.
REQ-038 Bench SHALL cover: N=3, out_ready low for 5 cycles on element (1,1) -> data_out, row and col stable, data_valid=1, no pop during stall.
REQ-039 Bench SHALL cover: N=2, fifo_empty=1 for 4 cycles before the third element -> FETCH holds, pop=0, then resumes; total pops=4.
REQ-040 Bench SHALL cover: rst=1 on the cycle after the second pop with N=3 -> next cycle IDLE, all outputs 0, no further pop; a new start then restarts at (0,0).
REQ-041 Bench SHALL cover: start pulsed while busy and N changed 3->2 mid-matrix -> ignored; exactly 9 elements delivered.
REQ-042 Bench SHALL cover, with FIFO_READER_DIM_CHK_EN: start with N=0 and then with N=9 (NMAX=8) -> err pulse each time, busy=0, pop=0.
